// File: rtl/attn_row_scheduler.sv
// attn_row_scheduler: buffers one query and NUM_KEYS key vectors from a byte
// stream, feeds interleaved q/k byte pairs to the attention engine one key at
// a time, and streams each returned exp() score downstream with a running sum.
module attn_row_scheduler #(
  parameter int NUM_KEYS = 4,
  parameter int SUM_W    = 9 + $clog2(NUM_KEYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic [7:0]       eng_data,
  output logic             eng_vld,
  input  logic             eng_rdy,
  input  logic [8:0]       eng_res,
  input  logic             eng_res_vld,
  output logic             eng_res_rdy,
  output logic [8:0]       out_score,
  output logic [SUM_W-1:0] out_sum,
  output logic             out_last,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             busy
);

  localparam int NBYTES = 4 + 4 * NUM_KEYS;
  localparam int LW     = $clog2(NBYTES);
  localparam int JW     = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT_RES,
    S_EMIT
  } state_t;

  state_t state_reg, state_next;

  // Flat buffer in load order: query bytes at 0..3, key j byte p at 4+4j+p.
  logic [7:0]       buf_mem [NBYTES];
  logic [LW-1:0]    load_idx_reg;
  logic [LW-1:0]    wr_addr;
  logic [LW-1:0]    rd_addr;
  logic [JW-1:0]    j_reg;
  logic [2:0]       b_reg;
  logic [2:0]       b_inc;
  logic [7:0]       eng_data_reg;
  logic [8:0]       score_reg;
  logic [SUM_W-1:0] sum_reg;
  logic             last_reg;
  logic             in_xfer;
  logic             eng_xfer;
  logic             load_done;
  logic             key_last;

  // Handshakes decode purely from state so no input reaches an output combinationally.
  assign in_rdy      = (state_reg == S_IDLE) || (state_reg == S_LOAD);
  assign eng_vld     = (state_reg == S_ISSUE);
  assign eng_res_rdy = (state_reg == S_WAIT_RES);
  assign out_vld     = (state_reg == S_EMIT);
  assign busy        = (state_reg != S_IDLE);

  assign eng_data  = eng_data_reg;
  assign out_score = score_reg;
  assign out_sum   = sum_reg;
  assign out_last  = last_reg;

  assign in_xfer   = in_vld && in_rdy;
  assign eng_xfer  = eng_vld && eng_rdy;
  assign load_done = (state_reg == S_LOAD) && (load_idx_reg == LW'(NBYTES - 1));
  assign key_last  = (j_reg == JW'(NUM_KEYS - 1));
  assign wr_addr   = (state_reg == S_IDLE) ? '0 : load_idx_reg;

  // Address of the byte that follows the current one: even slots are query
  // bytes, odd slots are bytes of the current key.
  assign b_inc   = b_reg + 3'd1;
  assign rd_addr = b_inc[0] ? LW'(4 + 4 * int'(j_reg) + int'(b_inc[2:1]))
                            : LW'(b_inc[2:1]);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:     if (in_xfer) state_next = S_LOAD;
      S_LOAD:     if (in_xfer && load_done) state_next = S_ISSUE;
      S_ISSUE:    if (eng_xfer && (b_reg == 3'd7)) state_next = S_WAIT_RES;
      S_WAIT_RES: if (eng_res_vld) state_next = S_EMIT;
      S_EMIT:     if (out_rdy) state_next = last_reg ? S_IDLE : S_ISSUE;
      default:    state_next = S_IDLE;
    endcase
  end

  // Counters, prefetched engine byte and downstream result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_idx_reg <= '0;
      j_reg        <= '0;
      b_reg        <= '0;
      eng_data_reg <= '0;
      score_reg    <= '0;
      sum_reg      <= '0;
      last_reg     <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (in_xfer) begin
            load_idx_reg <= LW'(1);
            sum_reg      <= '0;
            j_reg        <= '0;
          end
        end
        S_LOAD: begin
          if (in_xfer) begin
            load_idx_reg <= load_idx_reg + LW'(1);
            if (load_done) begin
              b_reg        <= 3'd0;
              eng_data_reg <= buf_mem[0];
            end
          end
        end
        S_ISSUE: begin
          if (eng_xfer) begin
            b_reg <= b_inc;
            if (b_reg != 3'd7) eng_data_reg <= buf_mem[rd_addr];
          end
        end
        S_WAIT_RES: begin
          if (eng_res_vld) begin
            score_reg <= eng_res;
            sum_reg   <= sum_reg + SUM_W'(eng_res);
            last_reg  <= key_last;
          end
        end
        S_EMIT: begin
          if (out_rdy && !last_reg) begin
            j_reg        <= j_reg + JW'(1);
            b_reg        <= 3'd0;
            eng_data_reg <= buf_mem[0];
          end
        end
        default: ;
      endcase
    end
  end

  // Byte buffer write; contents need no reset.
  always_ff @(posedge clk) begin
    if (in_xfer) buf_mem[wr_addr] <= in_data;
  end

endmodule

// File: tb/tb_attn_row_scheduler.sv
// tb_attn_row_scheduler: three scheduler instances (1, 4 and 8 keys) driven one
// at a time by directed queries; a compare process checks every engine byte and
// every downstream score against a model built from the query contents.
module tb_attn_row_scheduler;

  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data     [NI];
  logic       in_vld      [NI];
  logic       in_rdy      [NI];
  logic [7:0] eng_data    [NI];
  logic       eng_vld     [NI];
  logic       eng_rdy     [NI];
  logic [8:0] eng_res     [NI];
  logic       eng_res_vld [NI];
  logic       eng_res_rdy [NI];
  logic [8:0] out_score   [NI];
  logic [11:0] out_sum    [NI];
  logic       out_last    [NI];
  logic       out_vld     [NI];
  logic       out_rdy     [NI];
  logic       busy        [NI];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int NK = (gi == 0) ? 1 : ((gi == 1) ? 4 : 8);
    localparam int SW = 9 + $clog2(NK);
    logic [SW-1:0] sum_w;
    attn_row_scheduler #(.NUM_KEYS(NK)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_data     (in_data[gi]),
      .in_vld      (in_vld[gi]),
      .in_rdy      (in_rdy[gi]),
      .eng_data    (eng_data[gi]),
      .eng_vld     (eng_vld[gi]),
      .eng_rdy     (eng_rdy[gi]),
      .eng_res     (eng_res[gi]),
      .eng_res_vld (eng_res_vld[gi]),
      .eng_res_rdy (eng_res_rdy[gi]),
      .out_score   (out_score[gi]),
      .out_sum     (sum_w),
      .out_last    (out_last[gi]),
      .out_vld     (out_vld[gi]),
      .out_rdy     (out_rdy[gi]),
      .busy        (busy[gi])
    );
    assign out_sum[gi] = 12'(sum_w);
  end

  int n_vec = 0;
  int n_err = 0;

  // Query contents and model expectations.
  int q_v [4];
  int k_v [8][4];
  int r_v [8];
  int exp_eng [64];
  int exp_score [8];
  int exp_sum [8];
  int exp_last [8];
  int exp_neng, exp_nout;

  // Values seen by the compare process.
  int got_eng [64];
  int got_sum [8];
  int got_last [8];
  int e_ptr = 0;
  int o_ptr = 0;

  int cur = 0;
  int qid = 0;
  bit chk_en = 1'b0;
  bit stray_on = 1'b0;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  function automatic int nk_of(input int i);
    case (i)
      0:       return 1;
      1:       return 4;
      default: return 8;
    endcase
  endfunction

  function automatic int byte_at(input int li);
    if (li < 4) return q_v[li];
    return k_v[(li - 4) / 4][(li - 4) % 4];
  endfunction

  task automatic idle_inputs(input int i);
    in_vld[i]      = 1'b0;
    in_data[i]     = 8'h00;
    eng_rdy[i]     = 1'b0;
    eng_res[i]     = 9'h000;
    eng_res_vld[i] = 1'b0;
    out_rdy[i]     = 1'b0;
  endtask

  task automatic check_reset(input int i, input string tag);
    chk({tag, "_in_rdy"},      int'(in_rdy[i]), 1);
    chk({tag, "_eng_vld"},     int'(eng_vld[i]), 0);
    chk({tag, "_eng_data"},    int'(eng_data[i]), 0);
    chk({tag, "_eng_res_rdy"}, int'(eng_res_rdy[i]), 0);
    chk({tag, "_out_vld"},     int'(out_vld[i]), 0);
    chk({tag, "_out_last"},    int'(out_last[i]), 0);
    chk({tag, "_out_score"},   int'(out_score[i]), 0);
    chk({tag, "_out_sum"},     int'(out_sum[i]), 0);
    chk({tag, "_busy"},        int'(busy[i]), 0);
  endtask

  // Compare process: checks every transfer and every stall against the model.
  initial begin
    int i;
    int seen_qid;
    bit p_ev, p_er, p_ov, p_or;
    int p_ed, p_sc, p_su, p_la;
    seen_qid = 0;
    p_ev = 0; p_er = 0; p_ov = 0; p_or = 0;
    p_ed = 0; p_sc = 0; p_su = 0; p_la = 0;
    forever begin
      @(negedge clk);
      if (qid != seen_qid) begin
        seen_qid = qid;
        e_ptr = 0;
        o_ptr = 0;
      end
      if (!chk_en || !rst_n) begin
        p_ev = 0;
        p_ov = 0;
      end else begin
        i = cur;
        if (p_ev && !p_er) begin
          chk("eng_hold_vld", int'(eng_vld[i]), 1);
          chk("eng_hold_data", int'(eng_data[i]), p_ed);
        end
        if (p_ov && !p_or) begin
          chk("out_hold_vld", int'(out_vld[i]), 1);
          chk("out_hold_score", int'(out_score[i]), p_sc);
          chk("out_hold_sum", int'(out_sum[i]), p_su);
          chk("out_hold_last", int'(out_last[i]), p_la);
        end
        if (stray_on && eng_res_vld[i]) chk("stray_rdy", int'(eng_res_rdy[i]), 0);
        if (eng_vld[i] && eng_rdy[i]) begin
          if (e_ptr < exp_neng) begin
            chk("eng_data", int'(eng_data[i]), exp_eng[e_ptr]);
            got_eng[e_ptr] = int'(eng_data[i]);
          end else begin
            chk("eng_count", e_ptr + 1, exp_neng);
          end
          e_ptr++;
        end
        if (out_vld[i] && out_rdy[i]) begin
          if (o_ptr < exp_nout) begin
            chk("out_score", int'(out_score[i]), exp_score[o_ptr]);
            chk("out_sum", int'(out_sum[i]), exp_sum[o_ptr]);
            chk("out_last", int'(out_last[i]), exp_last[o_ptr]);
            got_sum[o_ptr]  = int'(out_sum[i]);
            got_last[o_ptr] = int'(out_last[i]);
          end else begin
            chk("out_count", o_ptr + 1, exp_nout);
          end
          o_ptr++;
        end
        p_ev = eng_vld[i]; p_er = eng_rdy[i]; p_ed = int'(eng_data[i]);
        p_ov = out_vld[i]; p_or = out_rdy[i];
        p_sc = int'(out_score[i]); p_su = int'(out_sum[i]); p_la = int'(out_last[i]);
      end
    end
  end

  // Runs one query on instance i. mode 0: no stalls; 1: random stalls;
  // 2: engine ready drops every third cycle. Entered and left at posedge+1.
  task automatic run_query(input int i, input int mode, input bit stray, input int abort_key);
    int nk, nb, li, ec, rk, oc, s;
    bit ix, ex, rx, ox, aborted;
    nk = nk_of(i);
    nb = 4 + 4 * nk;
    exp_neng = 8 * nk;
    s = 0;
    for (int j = 0; j < nk; j++) begin
      for (int p = 0; p < 4; p++) begin
        exp_eng[8*j + 2*p]     = q_v[p];
        exp_eng[8*j + 2*p + 1] = k_v[j][p];
      end
      s += r_v[j];
      exp_score[j] = r_v[j];
      exp_sum[j]   = s;
      exp_last[j]  = (j == nk - 1) ? 1 : 0;
    end
    exp_nout = nk;
    cur = i;
    qid++;
    chk_en = 1'b1;
    li = 0; ec = 0; rk = 0; oc = 0;
    aborted = 1'b0;
    for (int cyc = 0; cyc < 3000 && oc < nk && !aborted; cyc++) begin
      in_vld[i]  = (li < nb) && (mode != 1 || $urandom_range(0, 3) != 0);
      in_data[i] = (li < nb) ? 8'(byte_at(li)) : 8'h00;
      eng_rdy[i] = (mode == 0) ? 1'b1 : ((mode == 1) ? ($urandom_range(0, 2) != 0) : (cyc % 3 != 2));
      stray_on = 1'b0;
      if (rk < nk && ec >= 8 * (rk + 1)) begin
        eng_res_vld[i] = 1'b1;
        eng_res[i]     = 9'(r_v[rk]);
      end else if (stray && li > 0 && li < nb && (cyc % 2 == 0)) begin
        eng_res_vld[i] = 1'b1;
        eng_res[i]     = 9'h1AB;
        stray_on       = 1'b1;
      end else begin
        eng_res_vld[i] = 1'b0;
        eng_res[i]     = 9'h000;
      end
      out_rdy[i] = (mode == 0) ? 1'b1 : ($urandom_range(0, 1) != 0);
      @(negedge clk);
      ix = in_vld[i] && in_rdy[i];
      ex = eng_vld[i] && eng_rdy[i];
      rx = eng_res_vld[i] && eng_res_rdy[i] && !stray_on;
      ox = out_vld[i] && out_rdy[i];
      if (abort_key >= 0 && oc == abort_key && ec >= 8 * abort_key + 3 && eng_vld[i]) begin
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_reset(i, "abort");
        aborted = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        if (ix && li == nb - 1) chk("eng_vld_latency", int'(eng_vld[i]), 1);
        if (rx) chk("out_vld_latency", int'(out_vld[i]), 1);
        li += int'(ix);
        ec += int'(ex);
        rk += int'(rx);
        oc += int'(ox);
      end
    end
    idle_inputs(i);
    stray_on = 1'b0;
    if (!aborted) begin
      chk("outputs_done", oc, nk);
      chk("eng_total", e_ptr, exp_neng);
      chk("out_total", o_ptr, exp_nout);
      chk("busy_end", int'(busy[i]), 0);
    end
    chk_en = 1'b0;
  endtask

  task automatic fill_random(input int nk);
    for (int p = 0; p < 4; p++) q_v[p] = int'($urandom_range(0, 255));
    for (int j = 0; j < nk; j++)
      for (int p = 0; p < 4; p++) k_v[j][p] = int'($urandom_range(0, 255));
  endtask

  task automatic set_ramp_results;
    r_v[0] = 'h040; r_v[1] = 'h080; r_v[2] = 'h0C0; r_v[3] = 'h100;
  endtask

  task automatic check_ramp_sums(input string tag);
    int lit_sum [4];
    lit_sum[0] = 'h040; lit_sum[1] = 'h0C0; lit_sum[2] = 'h180; lit_sum[3] = 'h280;
    for (int n = 0; n < 4; n++) begin
      chk({tag, "_sum_lit"}, got_sum[n], lit_sum[n]);
      chk({tag, "_last_lit"}, got_last[n], (n == 3) ? 1 : 0);
    end
  endtask

  initial begin
    int lit_order [8];
    for (int i = 0; i < NI; i++) idle_inputs(i);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) check_reset(i, "rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // One key: byte interleave and sum equal to the single score.
    for (int p = 0; p < 4; p++) begin
      q_v[p]    = p + 1;
      k_v[0][p] = p + 5;
    end
    r_v[0] = 'h0AB;
    run_query(0, 0, 1'b0, -1);
    lit_order[0] = 1; lit_order[1] = 5; lit_order[2] = 2; lit_order[3] = 6;
    lit_order[4] = 3; lit_order[5] = 7; lit_order[6] = 4; lit_order[7] = 8;
    for (int n = 0; n < 8; n++) chk("order_lit", got_eng[n], lit_order[n]);
    chk("nk1_sum_lit", got_sum[0], 'h0AB);
    chk("nk1_last_lit", got_last[0], 1);

    // Four keys, ramp scores, stray results during the load.
    fill_random(4);
    set_ramp_results();
    run_query(1, 0, 1'b1, -1);
    check_ramp_sums("ramp");

    // Four keys with random stalls on every port plus stray results.
    fill_random(4);
    for (int j = 0; j < 4; j++) r_v[j] = int'($urandom_range(0, 511));
    run_query(1, 1, 1'b1, -1);

    // Four keys with engine ready dropping between pair bytes.
    fill_random(4);
    set_ramp_results();
    run_query(1, 2, 1'b0, -1);
    check_ramp_sums("pattern");

    // Eight keys of maximum score: sum must reach 0xFF8 without wrapping.
    fill_random(8);
    for (int j = 0; j < 8; j++) r_v[j] = 'h1FF;
    run_query(2, 1, 1'b0, -1);
    chk("max_sum_lit", got_sum[7], 'hFF8);

    // Reset in the middle of issuing key 2, then a clean query from zero.
    fill_random(4);
    set_ramp_results();
    run_query(1, 0, 1'b0, 2);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    fill_random(4);
    set_ramp_results();
    run_query(1, 0, 1'b0, -1);
    check_ramp_sums("post_abort");

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
